regfile_2r1w_init: RTL and testbench
====================================

// Module: regfile_2r1w_init
// PURPOSE
//  Parametrised register file: two read ports, one write port, with registered
//  reads and write-to-read bypass. A built-in sequencer loads every entry with a
//  known pattern after reset or on request. It is the datapath operand store for
//  the lab CPU: two source operands are read per cycle and one result is written.
// PARAMETERS
//  DATA_W    8   width of each entry, in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  INIT_MODE 0   0 = all-zero; 1 = pattern (entry i = (3*i+1) mod 2**DATA_W)
// PORTS
//  Clk       in   1       clock; all state changes on the rising edge
//  Rst       in   1       asynchronous, active-low reset
//  W_en      in   1       write enable
//  W_Addr    in   ADDR_W  write address
//  W_Data    in   DATA_W  write data
//  R0_en     in   1       read port 0 enable
//  R0_Addr   in   ADDR_W  read port 0 address
//  R0_Data   out  DATA_W  read port 0 data, registered
//  R1_en     in   1       read port 1 enable
//  R1_Addr   in   ADDR_W  read port 1 address
//  R1_Data   out  DATA_W  read port 1 data, registered
//  Init_req  in   1       request a re-initialisation of every entry
//  Busy      out  1       1 while the init sequence is running
//  W_drop    out  1       one-cycle pulse: a write was rejected
// BEHAVIOUR
//  - Reset (Rst=0, async): state=INIT, init counter=0, Busy=1, R0_Data=R1_Data=0,
//    W_drop=0. Array contents are undefined until INIT completes.
//  - FSM states: INIT and READY.
//    INIT: each edge writes init_value(cnt) into entry cnt, then increments cnt.
//      On the edge that writes entry DEPTH-1, go to READY; Busy=0 after that edge.
//      From reset release, INIT lasts exactly DEPTH edges.
//    READY: when Init_req=1 at an edge, go to INIT with cnt=0 and Busy=1.
//      The first init write happens on the next edge.
//  - Init_req is ignored while in INIT; the sequence does not restart.
//  - Writes: in READY with W_en=1 and Init_req=0, W_Data is written to W_Addr.
//    A write with W_en=1 while in INIT, or in the same cycle as Init_req=1, is
//    discarded and W_drop=1 for the following cycle; otherwise W_drop=0.
//  - Reads: one-cycle latency. With Rx_en=1 at edge e, Rx_Data after e holds
//    entry Rx_Addr. With Rx_en=0, Rx_Data holds its previous value. There is no
//    tristate output.
//  - Bypass (write-first): if an accepted write and an enabled read hit the same
//    address at the same edge, Rx_Data = W_Data. Both ports bypass independently.
//  - During INIT, enabled reads load 0 into Rx_Data. Disabled reads hold.
//  - Both read ports may use the same address; each returns the same data.
//  - The init counter is ADDR_W+1 bits wide so it can detect the terminal count
//    (no wrap ambiguity). Pattern arithmetic truncates to DATA_W bits.
//  - Asserting Rst mid-INIT or mid-operation restarts INIT from entry 0.
// STRUCTURE
//  - regfile_pkg: rf_state_e {RF_INIT, RF_READY}, the INIT_MODE constants, and a
//    function init_value(idx, mode, DATA_W).
//  - Sub-module regfile_init_seq: FSM, counter, Busy, and the init write port.
//    The top level muxes init vs. user writes and holds the array, read regs and
//    bypass logic.
// TESTING
//  1 Reset, INIT_MODE=1, DATA_W=8: Busy=1 for 32 edges, then 0. Reading entries
//    0, 5 and 31 returns 0x01, 0x10 and 0x5E.
//  2 W_en=1 with Busy=1: write to addr 3 with 0xAA -> W_drop=1 for one cycle;
//    entry 3 keeps its init value.
//  3 READY: write addr 7=0x3C while R0 reads addr 7 and R1 reads addr 8 in the
//    same cycle -> R0_Data=0x3C (bypass), R1_Data=init(8)=0x19.
//  4 Read with R0_en=0 after a read of 0x3C -> R0_Data stays 0x3C.
//  5 Init_req=1 together with W_en=1 (addr 2, 0x55) -> W_drop=1, Busy=1 for 32
//    cycles, then entry 2 = 0x07.
//  6 Rst pulsed low at INIT entry 12 -> outputs reset immediately; after release
//    there are a full 32 INIT edges, and Init_req during INIT is ignored.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write register file with built-in
// initialisation sequencer.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

  localparam int INIT_MODE_ZERO    = 0;
  localparam int INIT_MODE_PATTERN = 1;

  // Value loaded into entry idx at init; callers size-cast to their DATA_W.
  function automatic logic [31:0] init_value(input int unsigned idx,
                                             input int unsigned mode,
                                             input int unsigned data_w);
    logic [31:0] v;
    logic [31:0] mask;
    v    = (mode == INIT_MODE_PATTERN) ? 32'(3 * idx + 1) : 32'd0;
    mask = (data_w >= 32) ? '1 : ((32'd1 << data_w) - 32'd1);
    return v & mask;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Init sequencer: INIT/READY FSM, entry counter, Busy flag and the write port
// that loads every entry with its init value.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int INIT_MODE = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Init_req,
  output logic              Busy,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);

  // One extra counter bit keeps the terminal count unambiguous.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'((2 ** ADDR_W) - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  rf_state_e       state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults at the top of every combinational block prevent latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RF_READY: begin
        if (Init_req) begin
          state_d = RF_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    Busy      = (state_q == RF_INIT);
    init_addr = cnt_q[ADDR_W-1:0];
    init_data = DATA_W'(init_value(32'(cnt_q), INIT_MODE, DATA_W));
  end

endmodule

// File: rtl/regfile_2r1w_init.sv
// Two-read/one-write register file with registered reads, write-first bypass
// and an automatic init sequence after reset or on Init_req.
module regfile_2r1w_init
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int INIT_MODE = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              W_en,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_Addr,
  output logic [DATA_W-1:0] R0_Data,
  input  logic              R1_en,
  input  logic [ADDR_W-1:0] R1_Addr,
  output logic [DATA_W-1:0] R1_Data,
  input  logic              Init_req,
  output logic              Busy,
  output logic              W_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              user_we;
  logic              drop_d;
  logic [DATA_W-1:0] r0_d, r1_d;

  regfile_init_seq #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_MODE(INIT_MODE)
  ) u_init_seq (
    .Clk      (Clk),
    .Rst      (Rst),
    .Init_req (Init_req),
    .Busy     (Busy),
    .init_addr(init_addr),
    .init_data(init_data)
  );

  // A user write lands only in READY and not alongside a re-init request.
  always_comb begin
    user_we = W_en & ~Busy & ~Init_req;
    drop_d  = W_en & (Busy | Init_req);
  end

  // NOTE: the array is deliberately not reset; the init sequence defines its
  // contents, which keeps it mappable onto plain RAM/flop arrays.
  always_ff @(posedge Clk) begin
    if (Busy) begin
      mem[init_addr] <= init_data;
    end else if (user_we) begin
      mem[W_Addr] <= W_Data;
    end
  end

  // Next read data: zero during INIT, write-first bypass, else array contents.
  always_comb begin
    r0_d = mem[R0_Addr];
    r1_d = mem[R1_Addr];
    if (Busy) begin
      r0_d = '0;
      r1_d = '0;
    end else if (user_we) begin
      if (W_Addr == R0_Addr) r0_d = W_Data;
      if (W_Addr == R1_Addr) r1_d = W_Data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      R0_Data <= '0;
      R1_Data <= '0;
      W_drop  <= 1'b0;
    end else begin
      if (R0_en) R0_Data <= r0_d;
      if (R1_en) R1_Data <= r1_d;
      W_drop <= drop_d;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w_init.sv
// Directed bench for regfile_2r1w_init (pattern init, 8x32): expected outputs
// are queued when stimulus is applied and compared after the clock edge.
module tb_regfile_2r1w_init;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              W_en = 1'b0;
  logic [ADDR_W-1:0] W_Addr = '0;
  logic [DATA_W-1:0] W_Data = '0;
  logic              R0_en = 1'b0;
  logic [ADDR_W-1:0] R0_Addr = '0;
  logic [DATA_W-1:0] R0_Data;
  logic              R1_en = 1'b0;
  logic [ADDR_W-1:0] R1_Addr = '0;
  logic [DATA_W-1:0] R1_Data;
  logic              Init_req = 1'b0;
  logic              Busy;
  logic              W_drop;

  regfile_2r1w_init #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_MODE(1)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .W_en    (W_en),
    .W_Addr  (W_Addr),
    .W_Data  (W_Data),
    .R0_en   (R0_en),
    .R0_Addr (R0_Addr),
    .R0_Data (R0_Data),
    .R1_en   (R1_en),
    .R1_Addr (R1_Addr),
    .R1_Data (R1_Data),
    .Init_req(Init_req),
    .Busy    (Busy),
    .W_drop  (W_drop)
  );

  always #5 Clk = ~Clk;

  typedef enum int {P_R0, P_R1, P_BUSY, P_DROP} port_e;
  typedef struct {
    string       tag;
    port_e       port;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [DATA_W-1:0] pat(input int i);
    return DATA_W'(3 * i + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input port_e port, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  // One rising edge, then compare every queued expectation 1 ns later.
  task automatic tick();
    exp_t        e;
    logic [31:0] obs;
    @(posedge Clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.port)
        P_R0:    obs = 32'(R0_Data);
        P_R1:    obs = 32'(R1_Data);
        P_BUSY:  obs = 32'(Busy);
        default: obs = 32'(W_drop);
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic idle_inputs();
    W_en     = 1'b0;
    R0_en    = 1'b0;
    R1_en    = 1'b0;
    Init_req = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 Rst = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'd1);
    check("rst_r0", 32'(R0_Data), 32'd0);
    check("rst_r1", 32'(R1_Data), 32'd0);
    check("rst_drop", 32'(W_drop), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b1;

    // INIT after reset: 32 edges, dropped write at edge 3, zero read at edge 5
    for (int k = 1; k <= DEPTH; k++) begin
      W_en   = (k == 3);
      W_Addr = 5'd3;
      W_Data = 8'hAA;
      R0_en  = (k == 5);
      R0_Addr = 5'd0;
      expect_out($sformatf("init_busy_%0d", k), P_BUSY, 32'(k < DEPTH));
      if (k == 3) expect_out("drop_in_init", P_DROP, 32'd1);
      if (k == 4) expect_out("drop_one_cycle", P_DROP, 32'd0);
      if (k == 5) expect_out("read_in_init_zero", P_R0, 32'd0);
      tick();
    end
    idle_inputs();

    // Init pattern reads
    R0_en = 1'b1; R0_Addr = 5'd0;
    R1_en = 1'b1; R1_Addr = 5'd5;
    expect_out("init_e0", P_R0, 32'h01);
    expect_out("init_e5", P_R1, 32'h10);
    tick();
    R0_Addr = 5'd31;
    R1_Addr = 5'd3;
    expect_out("init_e31", P_R0, 32'h5E);
    expect_out("e3_kept_after_drop", P_R1, 32'(pat(3)));
    tick();

    // Write with bypass on R0, plain read on R1
    W_en = 1'b1; W_Addr = 5'd7; W_Data = 8'h3C;
    R0_Addr = 5'd7;
    R1_Addr = 5'd8;
    expect_out("bypass_r0", P_R0, 32'h3C);
    expect_out("init_e8", P_R1, 32'h19);
    expect_out("accepted_write_no_drop", P_DROP, 32'd0);
    tick();
    W_en = 1'b0;
    expect_out("array_e7", P_R0, 32'h3C);
    tick();

    // R0 disabled holds; R1 reads the written entry
    R0_en = 1'b0; R0_Addr = 5'd8;
    R1_Addr = 5'd7;
    expect_out("r0_hold", P_R0, 32'h3C);
    expect_out("r1_e7", P_R1, 32'h3C);
    tick();

    // Both ports on one address
    R0_en = 1'b1; R0_Addr = 5'd9;
    R1_Addr = 5'd9;
    expect_out("same_addr_r0", P_R0, 32'(pat(9)));
    expect_out("same_addr_r1", P_R1, 32'(pat(9)));
    tick();
    idle_inputs();

    // Init_req together with a write: write dropped, full re-init
    Init_req = 1'b1;
    W_en = 1'b1; W_Addr = 5'd2; W_Data = 8'h55;
    expect_out("reinit_busy", P_BUSY, 32'd1);
    expect_out("reinit_drop", P_DROP, 32'd1);
    tick();
    idle_inputs();
    for (int k = 1; k <= DEPTH; k++) begin
      expect_out($sformatf("reinit_busy_%0d", k), P_BUSY, 32'(k < DEPTH));
      if (k == 1) expect_out("reinit_drop_clear", P_DROP, 32'd0);
      tick();
    end
    R0_en = 1'b1; R0_Addr = 5'd2;
    R1_en = 1'b1; R1_Addr = 5'd7;
    expect_out("reinit_e2", P_R0, 32'h07);
    expect_out("reinit_e7", P_R1, 32'(pat(7)));
    tick();
    idle_inputs();

    // Async reset in the middle of INIT
    Init_req = 1'b1;
    tick();
    Init_req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      W_en = (k == 12);
      if (k == 12) expect_out("drop_before_rst", P_DROP, 32'd1);
      tick();
    end
    W_en = 1'b0;
    Rst = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd1);
    check("midrst_r0", 32'(R0_Data), 32'd0);
    check("midrst_r1", 32'(R1_Data), 32'd0);
    check("midrst_drop", 32'(W_drop), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      Init_req = (k == 10);
      expect_out($sformatf("rst_init_busy_%0d", k), P_BUSY, 32'(k < DEPTH));
      tick();
    end
    idle_inputs();
    R0_en = 1'b1; R0_Addr = 5'd12;
    R1_en = 1'b1; R1_Addr = 5'd31;
    expect_out("post_rst_e12", P_R0, 32'h25);
    expect_out("post_rst_e31", P_R1, 32'h5E);
    tick();

    // Bypass on R1 only
    W_en = 1'b1; W_Addr = 5'd20; W_Data = 8'hC3;
    R0_Addr = 5'd21;
    R1_Addr = 5'd20;
    expect_out("bypass_r1", P_R1, 32'hC3);
    expect_out("r0_e21", P_R0, 32'h40);
    tick();
    W_en = 1'b0;
    R1_en = 1'b0;
    R0_Addr = 5'd20;
    expect_out("array_e20", P_R0, 32'hC3);
    expect_out("r1_hold", P_R1, 32'hC3);
    tick();
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
